serial_paralelo: RTL and testbench

- Receiver end of the 10-bit serial link: deserialises the LSB-first bit stream produced by the team's parallel-to-serial transmitter back into 10-bit words.
- Frames word boundaries by hunting for a comma symbol, then emits one registered word plus a one-cycle valid strobe every cantidadBits clocks.
- Re-aligns automatically when a comma appears off the current boundary.
- Sits between the serial line and the downstream 10b decoder.

---
 rtl/serial_paralelo_if.sv | 27 ++
 rtl/serial_paralelo.sv | 107 ++++++++++
 tb/tb_serial_paralelo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial line and deserialised-word bus of the 10-bit link
// receiver.
//   entrada          serial bit, LSB of each word first
//   salida           last complete word (bit 0 = first bit received)
//   valido           one-cycle strobe, salida updated on this edge
//   alineado         word boundary locked
//   errorAlineacion  one-cycle strobe, comma found off the locked boundary
// Modports: master = line/consumer side, slave = receiver.
interface serial_paralelo_if #(
   parameter int cantidadBits = 10
);
   logic                    entrada;
   logic [cantidadBits-1:0] salida;
   logic                    valido;
   logic                    alineado;
   logic                    errorAlineacion;

   modport master (
      output entrada,
      input  salida, valido, alineado, errorAlineacion
   );

   modport slave (
      input  entrada,
      output salida, valido, alineado, errorAlineacion
   );
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: receiver end of the 10-bit serial link. Shifts the LSB-first
// bit stream into a window, hunts for a comma (either disparity) to frame word
// boundaries, then emits one registered word with a valid strobe every
// cantidadBits clocks. A comma seen off the locked boundary forces re-alignment
// and raises errorAlineacion for one cycle.
// Ports:
//   clk          clock, all state changes on posedge
//   rstContador  asynchronous active-high reset, discards any partial word
//   bus          serial_paralelo_if.slave (entrada in; salida, valido,
//                alineado, errorAlineacion out)
module serial_paralelo #(
   parameter int                      cantidadBits = 10,
   parameter logic [cantidadBits-1:0] comma        = 10'b0011111010
) (
   input  logic                clk,
   input  logic                rstContador,
   serial_paralelo_if.slave    bus
);

   localparam int CW = (cantidadBits > 1) ? $clog2(cantidadBits) : 1;
   localparam int LW = $clog2(cantidadBits + 1);
   localparam logic [CW-1:0] ULTIMO = CW'(cantidadBits - 1);
   localparam logic [LW-1:0] LLENO  = LW'(cantidadBits);
   localparam logic [LW-1:0] CASI   = LW'(cantidadBits - 1);

   typedef enum logic {BUSCANDO, ALINEADO} estado_t;

   estado_t                 estado, estadoNext;
   logic [cantidadBits-1:0] ventana, ventanaNext;
   logic [cantidadBits-1:0] salida, salidaNext;
   logic [LW-1:0]           llenado, llenadoNext;
   logic [CW-1:0]           contador, contadorNext;
   logic                    valido, validoNext;
   logic                    errorAl, errorAlNext;
   logic                    esComma;

   always_ff @(posedge clk or posedge rstContador) begin
      if (rstContador) begin
         estado   <= BUSCANDO;
         ventana  <= '0;
         salida   <= '0;
         llenado  <= '0;
         contador <= '0;
         valido   <= 1'b0;
         errorAl  <= 1'b0;
      end else begin
         estado   <= estadoNext;
         ventana  <= ventanaNext;
         salida   <= salidaNext;
         llenado  <= llenadoNext;
         contador <= contadorNext;
         valido   <= validoNext;
         errorAl  <= errorAlNext;
      end
   end

   always_comb begin
      estadoNext   = estado;
      salidaNext   = salida;
      contadorNext = contador;
      validoNext   = 1'b0;
      errorAlNext  = 1'b0;

      // New bit enters at the MSB so that after cantidadBits shifts bit 0
      // holds the first bit received.
      ventanaNext = {bus.entrada, ventana[cantidadBits-1:1]};
      llenadoNext = (llenado == LLENO) ? llenado : llenado + 1'b1;

      // Only a completely filled window may match; the reset zeros would
      // otherwise complete a partial comma.
      esComma = ((ventanaNext == comma) || (ventanaNext == ~comma)) &&
                (llenado >= CASI);

      case (estado)
         BUSCANDO: begin
            if (esComma) begin
               salidaNext   = ventanaNext;
               validoNext   = 1'b1;
               contadorNext = '0;
               estadoNext   = ALINEADO;
            end
         end
         ALINEADO: begin
            if (contador == ULTIMO) begin
               // On-boundary word, comma or not.
               salidaNext   = ventanaNext;
               validoNext   = 1'b1;
               contadorNext = '0;
            end else if (esComma) begin
               salidaNext   = ventanaNext;
               validoNext   = 1'b1;
               errorAlNext  = 1'b1;
               contadorNext = '0;
            end else begin
               contadorNext = contador + 1'b1;
            end
         end
         default: estadoNext = BUSCANDO;
      endcase
   end

   assign bus.salida          = salida;
   assign bus.valido          = valido;
   assign bus.errorAlineacion = errorAl;
   assign bus.alineado        = (estado == ALINEADO);

endmodule

// File: tb/tb_serial_paralelo.sv
module tb_serial_paralelo;

   logic clk = 1'b0;
   logic rstContador = 1'b1;
   always #5 clk = ~clk;

   serial_paralelo_if #(.cantidadBits(10)) bus ();

   serial_paralelo #(
      .cantidadBits(10),
      .comma(10'b0011111010)
   ) dut (
      .clk(clk),
      .rstContador(rstContador),
      .bus(bus)
   );

   typedef struct {
      logic [9:0] w;
      logic       e;
      int         c;
   } exp_t;

   exp_t q[$];
   int compared   = 0;
   int mismatched = 0;
   int ciclo;
   int nbits      = 0;
   int nvalid     = 0;

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Edges since reset release: edge k sets ciclo == k.
   always @(posedge clk or posedge rstContador) begin
      if (rstContador) ciclo <= 0;
      else             ciclo <= ciclo + 1;
   end

   // Monitor: pops the scoreboard whenever the DUT strobes valido.
   always @(negedge clk) begin
      exp_t e;
      chk("error_sin_valido", int'(bus.errorAlineacion & ~bus.valido), 0);
      if (bus.valido) begin
         nvalid++;
         if (q.size() == 0) begin
            chk("valido_inesperado", 1, 0);
         end else begin
            e = q.pop_front();
            chk("salida", int'(bus.salida), int'(e.w));
            chk("errorAlineacion", int'(bus.errorAlineacion), int'(e.e));
            chk("ciclo_valido", ciclo, e.c);
         end
      end
   end

   task automatic send_bit(input logic b);
      bus.entrada = b;
      nbits++;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   // Expect a word whose last bit is sampled 'off' edges from now.
   task automatic expect_word(input logic [9:0] w, input logic e, input int off);
      exp_t x;
      x.w = w;
      x.e = e;
      x.c = nbits + off;
      q.push_back(x);
   endtask

   // Assert reset between edges and check outputs clear immediately.
   task automatic reset_async();
      #2;
      rstContador = 1'b1;
      #1;
      chk("rst_salida", int'(bus.salida), 0);
      chk("rst_valido", int'(bus.valido), 0);
      chk("rst_alineado", int'(bus.alineado), 0);
      chk("rst_error", int'(bus.errorAlineacion), 0);
      q.delete();
      nbits = 0;
      bus.entrada = 1'b0;
      @(posedge clk);
      #1;
      rstContador = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] pal;
      int n0;
      bus.entrada = 1'b0;
      #2;
      chk("init_salida", int'(bus.salida), 0);
      chk("init_alineado", int'(bus.alineado), 0);
      @(posedge clk);
      #1;
      rstContador = 1'b0;

      // Lock on RD- comma, then a data word.
      expect_word(10'h0FA, 1'b0, 10);
      send_word(10'h0FA);
      chk("lock_alineado", int'(bus.alineado), 1);
      expect_word(10'h155, 1'b0, 10);
      send_word(10'h155);

      // Partial word then reset mid-cycle.
      pal = 10'h155;
      for (int i = 0; i < 5; i++) send_bit(pal[i]);
      reset_async();

      // Nine bits making ventanaNext equal to the comma on the 9th edge.
      n0 = nvalid;
      pal = 10'b0011111010;
      for (int i = 1; i < 10; i++) send_bit(pal[i]);
      chk("guard_valido", int'(bus.valido), 0);
      chk("guard_alineado", int'(bus.alineado), 0);
      chk("guard_nvalid", nvalid, n0);
      reset_async();

      // RD+ comma after three junk bits.
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      expect_word(10'h305, 1'b0, 10);
      send_word(10'h305);
      chk("rdp_alineado", int'(bus.alineado), 1);
      expect_word(10'h2AA, 1'b0, 10);
      send_word(10'h2AA);
      reset_async();

      // Slip: one extra bit before a comma.
      expect_word(10'h0FA, 1'b0, 10);
      send_word(10'h0FA);
      expect_word(10'h155, 1'b0, 10);
      send_word(10'h155);
      expect_word(10'h155, 1'b0, 10);
      send_word(10'h155);
      expect_word(10'h1F4, 1'b0, 10);
      expect_word(10'h0FA, 1'b1, 11);
      send_bit(1'b0);
      send_word(10'h0FA);
      expect_word(10'h155, 1'b0, 10);
      send_word(10'h155);

      // Steady comma train.
      for (int k = 0; k < 5; k++) begin
         expect_word(10'h0FA, 1'b0, 10);
         send_word(10'h0FA);
      end
      chk("tren_alineado", int'(bus.alineado), 1);

      repeat (3) @(posedge clk);
      #1;
      chk("cola_vacia", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
